// File: rtl/led_bar_driver.sv
// LED bar/dot level display with peak-hold and stepwise peak decay.
// Optional PWM brightness gating on dout when LED_BAR_PWM_EN is defined.
//
// state | meaning
// TRACK | peak follows level
// HOLD  | peak frozen for HOLD_CYC clocks after a new maximum
// DECAY | peak steps down by one every DECAY_CYC clocks until it meets level
module led_bar_driver #(
    parameter int N_LED     = 8,
    parameter int VAL_W     = 4,
    parameter int HOLD_CYC  = 50_000_000,
    parameter int DECAY_CYC = 5_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VAL_W-1:0]             din,
    input  logic                         din_vld,
    input  logic                         mode,
`ifdef LED_BAR_PWM_EN
    input  logic [3:0]                   bright,
`endif
    output logic [N_LED-1:0]             dout,
    output logic                         seg,
    output logic [$clog2(N_LED+1)-1:0]   peak
);

    localparam int LW = $clog2(N_LED + 1);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int DW = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;

    localparam logic [1:0] TRACK = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DECAY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    peak_q, peak_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [DW-1:0]    decay_q, decay_d;
    logic [N_LED-1:0] dout_q;
    logic             seg_q;
    logic [LW-1:0]    sat;
    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_gated;

    always_comb begin
        sat = (32'(din) > 32'(N_LED)) ? LW'(N_LED) : LW'(din);
    end

    always_comb begin
        level_d = din_vld ? sat : level_q;
        peak_d  = peak_q;
        state_d = state_q;
        hold_d  = hold_q;
        decay_d = decay_q;

        // A new maximum always wins over any counter action this cycle.
        if (din_vld && (sat >= peak_q)) begin
            peak_d  = sat;
            hold_d  = HW'(HOLD_CYC - 1);
            state_d = HOLD;
        end else begin
            case (state_q)
                TRACK: peak_d = level_d;
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d = DECAY;
                        decay_d = DW'(DECAY_CYC - 1);
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                DECAY: begin
                    if (decay_q == '0) begin
                        peak_d  = peak_q - LW'(1);
                        decay_d = DW'(DECAY_CYC - 1);
                    end else begin
                        decay_d = decay_q - DW'(1);
                    end
                end
                default: state_d = TRACK;
            endcase
        end

        // Once the decaying peak reaches the live level, go back to tracking.
        if ((state_d == DECAY) && (peak_d <= level_d)) begin
            state_d = TRACK;
            peak_d  = level_d;
        end
    end

    always_comb begin
        pat = '0;
        for (int i = 0; i < N_LED; i++) begin
            pat[i] = mode ? (int'(level_q) == i + 1) : (i < int'(level_q));
            if (int'(peak_q) == i + 1) begin
                pat[i] = 1'b1;
            end
        end
    end

`ifdef LED_BAR_PWM_EN
    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
        end
    end

    assign pat_gated = (pwm_cnt_q < bright) ? pat : '0;
`else
    assign pat_gated = pat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRACK;
            level_q <= '0;
            peak_q  <= '0;
            hold_q  <= '0;
            decay_q <= '0;
            dout_q  <= '0;
            seg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
            dout_q  <= pat_gated;
            seg_q   <= 1'b1;
        end
    end

    assign dout = dout_q;
    assign seg  = seg_q;
    assign peak = peak_q;

endmodule

// File: tb/tb_led_bar_driver.sv
// Directed bench for led_bar_driver (N_LED=8, VAL_W=4, HOLD_CYC=4, DECAY_CYC=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_bar_driver;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       din_vld;
    logic       mode;
    logic [7:0] dout;
    logic       seg;
    logic [3:0] peak;
`ifdef LED_BAR_PWM_EN
    logic [3:0] bright;
    logic [3:0] pwm_m;
`endif

    int checks = 0;
    int errors = 0;

    led_bar_driver #(
        .N_LED(8), .VAL_W(4), .HOLD_CYC(4), .DECAY_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_vld(din_vld),
        .mode(mode),
`ifdef LED_BAR_PWM_EN
        .bright(bright),
`endif
        .dout(dout),
        .seg(seg),
        .peak(peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LED_BAR_PWM_EN
    // Bench-side phase of the free-running brightness counter.
    always @(posedge clk or posedge rst) begin
        if (rst) pwm_m <= 4'd0;
        else     pwm_m <= pwm_m + 4'd1;
    end
`endif

    function automatic logic [7:0] gate(input logic [7:0] p);
`ifdef LED_BAR_PWM_EN
        logic [3:0] ph;
        ph = pwm_m - 4'd1;
        return (ph < bright) ? p : 8'h00;
`else
        return p;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample(input logic [3:0] v);
        din     = v;
        din_vld = 1'b1;
        tick(1);
        din_vld = 1'b0;
    endtask

    initial begin
        int n_on;
        rst     = 1'b1;
        din     = 4'd0;
        din_vld = 1'b0;
        mode    = 1'b0;
`ifdef LED_BAR_PWM_EN
        bright  = 4'd15;
`endif
        tick(2);
        chk("rst_dout", dout, 8'h00);
        chk("rst_seg", seg, 1'b0);
        chk("rst_peak", peak, 4'd0);
        rst = 1'b0;
        tick(1);
        chk("seg_rise", seg, 1'b1);
        chk("idle_dout", dout, gate(8'h00));

        // Bar mode: rise to 5, lower sample to 2, hold then decay back to 2.
        sample(4'd5);
        chk("s1_peak", peak, 4'd5);
        chk("s1_dout_lat1", dout, gate(8'h00));
        tick(1);
        chk("s1_dout", dout, gate(8'h1F));
        sample(4'd2);
        chk("s2_peak_held", peak, 4'd5);
        chk("s2_dout_lat", dout, gate(8'h1F));
        tick(1);
        chk("s2_dout", dout, gate(8'h13));
        tick(2);
        chk("s2_hold_end_peak", peak, 4'd5);
        tick(1);
        chk("s2_decay4", peak, 4'd4);
        tick(1);
        chk("s2_dout4", dout, gate(8'h0B));
        tick(1);
        chk("s2_decay3", peak, 4'd3);
        tick(2);
        chk("s2_decay2", peak, 4'd2);
        tick(1);
        chk("s2_dout_end", dout, gate(8'h03));
        tick(3);
        chk("s2_floor_peak", peak, 4'd2);
        chk("s2_floor_dout", dout, gate(8'h03));
        sample(4'd1);
        chk("track_follow", peak, 4'd1);
        tick(1);
        chk("track_dout", dout, gate(8'h01));

        // Saturation.
        sample(4'd12);
        chk("s3_peak_sat", peak, 4'd8);
        tick(1);
        chk("s3_dout", dout, gate(8'hFF));

        // Asynchronous reset while holding.
        #2 rst = 1'b1;
        #1;
        chk("s6_async_dout", dout, 8'h00);
        chk("s6_async_seg", seg, 1'b0);
        chk("s6_async_peak", peak, 4'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("s6_seg_back", seg, 1'b1);
        chk("s6_dout_clear", dout, gate(8'h00));

        // Dot mode with held peak.
        mode = 1'b1;
        sample(4'd6);
        chk("s4_peak", peak, 4'd6);
        sample(4'd3);
        chk("s4_dout_pk", dout, gate(8'h20));
        chk("s4_peak_held", peak, 4'd6);
        tick(1);
        chk("s4_dout", dout, gate(8'h24));

        // New maximum arriving on the edge a decay step was due.
        tick(6);
        chk("s5_peak4", peak, 4'd4);
        chk("s5_dout_dec", dout, gate(8'h14));
        tick(1);
        chk("s5_peak4_wait", peak, 4'd4);
        sample(4'd7);
        chk("s5_peak7", peak, 4'd7);
        sample(4'd1);
        tick(4);
        chk("s5_hold_restart", peak, 4'd7);
        tick(1);
        chk("s5_decay6", peak, 4'd6);
        chk("s5_dout", dout, gate(8'h41));

`ifdef LED_BAR_PWM_EN
        bright = 4'd4;
        tick(1);
        n_on = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (dout != 8'h00) n_on++;
        end
        chk("pwm_on_count", n_on, 4);
`else
        n_on = 0;
`endif
        chk("seg_final", seg, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_bar_driver.md
LED_BAR_DRIVER -- requirements
Module: led_bar_driver

Interface
REQ-001 Parameter N_LED, default 8: number of bar LEDs; legal range 2..32.
REQ-002 Parameter VAL_W, default 4: input level width.
REQ-003 Parameter HOLD_CYC, default 50_000_000: peak-hold duration in clocks; must be at least 1.
REQ-004 Parameter DECAY_CYC, default 5_000_000: clocks per one-step peak decay; must be at least 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: rising-edge clock.
REQ-007 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port din, input, VAL_W bits: new level value.
REQ-009 Port din_vld, input, 1 bit: din is sampled on a rising edge when this is 1.
REQ-010 Port mode, input, 1 bit: display mode; 0 = bar (thermometer), 1 = dot.
REQ-011 Port dout, output, N_LED bits: registered LED drive; bit 0 is the lowest LED.
REQ-012 Port seg, output, 1 bit: registered display enable.
REQ-013 Port peak, output, clog2(N_LED+1) bits: current held peak value.

Function
REQ-014 On an edge with din_vld=1, the level register SHALL load min(din, N_LED); this saturates the value and never wraps.
REQ-015 With din_vld=0, the level register SHALL hold its value.
REQ-016 dout SHALL reflect the level and peak values registered at edge E0 at the following edge E1, giving 1 clock of latency from the level register and 2 edges from the din sample.
REQ-017 Bar mode: dout[i]=1 for i<level; additionally dout[peak-1]=1 when peak>0.
REQ-018 Dot mode: dout[level-1]=1 when level>0; dout[peak-1]=1 when peak>0; all other bits are 0.
REQ-019 When level=0 and peak=0, dout SHALL be all zeros.
REQ-020 The peak FSM SHALL have three states: TRACK, HOLD and DECAY.
REQ-021 In any state, a sample with min(din,N_LED) >= peak SHALL load peak with that value, reload the hold counter to HOLD_CYC-1 and enter HOLD. This rule takes priority over the counter actions in REQ-022 and REQ-023.
REQ-022 In HOLD, the hold counter SHALL decrement each clock; at 0 the FSM SHALL enter DECAY with the decay counter set to DECAY_CYC-1.
REQ-023 In DECAY, peak SHALL decrement by 1 each time the decay counter reaches 0, after which the counter reloads.
REQ-024 The FSM SHALL enter TRACK when peak <= level; peak is never decremented below level.
REQ-025 In TRACK, peak SHALL equal level; a level increase is handled by REQ-021.
REQ-026 A lower sample during HOLD or DECAY SHALL update level only; peak and the counters are unaffected.

Reset
REQ-027 While rst=1, the block SHALL hold level=0, peak=0, dout=0 and seg=0, with the FSM in TRACK and all counters at 0.
REQ-028 seg SHALL go to 1 on the first clock edge after rst deasserts and stay 1 thereafter (0 only while rst=1).
REQ-029 A reset asserted mid-HOLD or mid-DECAY SHALL clear all state immediately, independent of clk.

Configuration
REQ-030 Macro LED_BAR_PWM_EN, when defined, SHALL add an input port bright (4 bits) and a free-running 4-bit PWM counter that is reset to 0.
REQ-031 With LED_BAR_PWM_EN defined, dout SHALL be gated to 0 on cycles where pwm_cnt >= bright (bright=0 gives always off; bright=15 gives 15/16 on); seg is ungated.
REQ-032 Without LED_BAR_PWM_EN, the bright port and the PWM counter SHALL be absent and dout SHALL be ungated.

Verification
Common bench parameters: N_LED=8, VAL_W=4, HOLD_CYC=4, DECAY_CYC=2.
REQ-033 Scenario 1: reset, then bar mode with din=5 and din_vld for 1 clock -> dout=8'b00011111 two edges after the sample, peak=5.
REQ-034 Scenario 2: continuing, din=2 with din_vld -> dout=8'b00010011; after 4 hold clocks, peak steps 5->4->3->2 every 2 clocks, dout ends at 8'b00000011 and the FSM returns to TRACK.
REQ-035 Scenario 3: din=12 with din_vld -> level=8, peak=8, dout=8'hFF (saturation, no wrap).
REQ-036 Scenario 4: dot mode, din=6 followed by din=3 -> dout=8'b00100100 while peak is held.
REQ-037 Scenario 5: during DECAY with peak=4, din=7 with din_vld -> peak=7, hold restarts, no decrement occurs on that edge.
REQ-038 Scenario 6: assert rst during HOLD -> dout=0, seg=0 and peak=0 asynchronously; with LED_BAR_PWM_EN and bright=4, dout is nonzero 4 of every 16 clocks.
